// File: rtl/chip8_mem_pkg.sv
// Shared types and constants for the Chip-8 main-memory arbiter.
// Widths here match the 4 KB single-port RAM and size the arbiter interface.
package chip8_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  // First address the CPU may write when write protection is compiled in;
  // everything below it holds the interpreter area and font set.
  localparam logic [ADDR_W-1:0] PROT_LIMIT_DEFAULT = 12'h200;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CPU  = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // One entry of the read-return tag pipeline.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
// slave  : the arbiter's view (takes requests and RAM data, drives grants,
//          read returns and the RAM command).
// master : the surrounding system's view (requesters plus RAM).
interface chip8_mem_arbiter_if;
  import chip8_mem_pkg::*;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/chip8_rd_tag_pipe.sv
// Two-stage {valid, owner} shift register that follows each read through
// the command register and the RAM, so the data is returned to its issuer.
// Synchronous active-low clear drops any reads still in flight.
module chip8_rd_tag_pipe
  import chip8_mem_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage0_q;
  rd_tag_t stage1_q;

  // Shift the tag one stage per cycle; clear discards in-flight reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage0_q <= '0;
      stage1_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let stage1_q take the old stage0_q,
      // giving a true two-stage shift regardless of statement order.
      stage0_q <= tag_i;
      stage1_q <= stage0_q;
    end
  end

  assign tag_o = stage1_q;

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Round-robin arbiter for the single-port 4 KB Chip-8 main memory.
// Host bus and CPU core compete for one registered RAM command per cycle;
// read data comes back two cycles after the grant, steered by owner tag.
// CPU requests only count while run is high.
// Optional: define CHIP8_ARB_PROTECT_EN to block CPU writes below
// PROT_LIMIT (request consumed, no RAM write, sticky prot_err).
module chip8_mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PROT_LIMIT = PROT_LIMIT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  chip8_mem_arbiter_if.slave  bus,
  output logic                prot_err
);

`ifdef CHIP8_ARB_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic     host_v;
  logic     cpu_v;
  logic     host_gnt;
  logic     cpu_gnt;
  logic     prot_block;
  logic     host_rvalid;
  logic     cpu_rvalid;

  mem_cmd_t cmd_d, cmd_q;
  logic     mem_en_d, mem_en_q;
  owner_t   last_owner_d, last_owner_q;
  logic     prot_err_d, prot_err_q;
  rd_tag_t  tag_d, tag_q;

  logic [DATA_W-1:0] host_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  assign host_v = bus.host_req;
  assign cpu_v  = bus.cpu_req & run;

  // A CPU write into the protected low region; only acts when compiled in.
  assign prot_block = PROT_EN && bus.cpu_we && (bus.cpu_addr < PROT_LIMIT);

  // Grant: sole requester wins; on conflict the one that did not go last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    host_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    if (host_v && cpu_v) begin
      if (last_owner_q == OWN_CPU) host_gnt = 1'b1;
      else                         cpu_gnt  = 1'b1;
    end else begin
      host_gnt = host_v;
      cpu_gnt  = cpu_v;
    end
  end

  // Next RAM command, owner history, protection flag and read tag.
  always_comb begin
    cmd_d    = cmd_q;
    cmd_d.we = 1'b0;
    mem_en_d = 1'b0;
    if (host_gnt) begin
      cmd_d    = '{we: bus.host_we, addr: bus.host_addr, wdata: bus.host_wdata};
      mem_en_d = 1'b1;
    end else if (cpu_gnt && !prot_block) begin
      cmd_d    = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
      mem_en_d = 1'b1;
    end

    last_owner_d = last_owner_q;
    if (host_gnt)     last_owner_d = OWN_HOST;
    else if (cpu_gnt) last_owner_d = OWN_CPU;

    prot_err_d = prot_err_q | (cpu_gnt & prot_block);

    tag_d.valid = (host_gnt & ~bus.host_we) | (cpu_gnt & ~bus.cpu_we);
    tag_d.owner = cpu_gnt ? OWN_CPU : OWN_HOST;
  end

  // Register the RAM command, arbitration history and held read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: only control and small datapath registers exist here, so all
      // of them are reset; the RAM itself lives outside this block.
      cmd_q        <= '0;
      mem_en_q     <= 1'b0;
      last_owner_q <= OWN_CPU;
      prot_err_q   <= 1'b0;
      host_rdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      cmd_q        <= cmd_d;
      mem_en_q     <= mem_en_d;
      last_owner_q <= last_owner_d;
      prot_err_q   <= prot_err_d;
      if (host_rvalid) host_rdata_q <= bus.mem_rdata;
      if (cpu_rvalid)  cpu_rdata_q  <= bus.mem_rdata;
    end
  end

  chip8_rd_tag_pipe u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_d),
    .tag_o (tag_q)
  );

  // RAM data is valid in the same cycle the tag leaves the pipe, so the
  // return path passes it straight through and holds it afterwards.
  assign host_rvalid = tag_q.valid && (tag_q.owner == OWN_HOST);
  assign cpu_rvalid  = tag_q.valid && (tag_q.owner == OWN_CPU);

  assign bus.host_gnt    = host_gnt;
  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.host_rvalid = host_rvalid;
  assign bus.cpu_rvalid  = cpu_rvalid;
  assign bus.host_rdata  = host_rvalid ? bus.mem_rdata : host_rdata_q;
  assign bus.cpu_rdata   = cpu_rvalid  ? bus.mem_rdata : cpu_rdata_q;

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = cmd_q.we;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;

  assign prot_err = prot_err_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a behavioural 4 KB RAM.
// Inputs change 1 ns after a rising edge; grants are sampled 1 ns later,
// registered outputs 1 ns after the following rising edge.
module tb_chip8_mem_arbiter;
  import chip8_mem_pkg::*;

`ifdef CHIP8_ARB_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic prot_err;

  int checks = 0;
  int errors = 0;

  chip8_mem_arbiter_if bus ();

  logic [DATA_W-1:0] ram [0:4095];
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  chip8_mem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .bus      (bus),
    .prot_err (prot_err)
  );

  // Single-port synchronous RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_rdata <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    #1;
    check("hw_gnt", bus.host_gnt, 1);
    tick();
    bus.host_req = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    run            = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    tick();
    tick();

    // Reset state
    check("rst_mem_en",    bus.mem_en, 0);
    check("rst_mem_we",    bus.mem_we, 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_h_rvalid",  bus.host_rvalid, 0);
    check("rst_c_rvalid",  bus.cpu_rvalid, 0);
    check("rst_h_rdata",   bus.host_rdata, 0);
    check("rst_prot_err",  prot_err, 0);
    reset = 1'b1;

    // Host-only write 0xAB to 0x300, then read it back
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 12'h300;
    bus.host_wdata = 8'hAB;
    #1;
    check("t1_wr_hgnt", bus.host_gnt, 1);
    check("t1_wr_cgnt", bus.cpu_gnt, 0);
    tick();
    check("t1_wr_en",    bus.mem_en, 1);
    check("t1_wr_we",    bus.mem_we, 1);
    check("t1_wr_addr",  bus.mem_addr, 12'h300);
    check("t1_wr_wdata", bus.mem_wdata, 8'hAB);
    bus.host_we = 1'b0;
    #1;
    check("t1_rd_hgnt", bus.host_gnt, 1);
    tick();
    check("t1_rd_en",     bus.mem_en, 1);
    check("t1_rd_we",     bus.mem_we, 0);
    check("t1_rd_early",  bus.host_rvalid, 0);
    bus.host_req = 1'b0;
    tick();
    check("t1_rvalid",    bus.host_rvalid, 1);
    check("t1_rdata",     bus.host_rdata, 8'hAB);
    check("t1_c_rvalid",  bus.cpu_rvalid, 0);
    check("t1_idle_en",   bus.mem_en, 0);
    tick();
    check("t1_rvalid_lo", bus.host_rvalid, 0);
    check("t1_rdata_hold", bus.host_rdata, 8'hAB);

    host_write(12'h301, 8'hCD);
    host_write(12'h050, 8'h11);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst2_h_rdata", bus.host_rdata, 0);

    // Both requesting from reset: host, cpu, host, cpu; returns in order
    run            = 1'b1;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 12'h300;
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 12'h301;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        check($sformatf("t2_h_rvalid%0d", i), bus.host_rvalid, (i % 2 == 0));
        check($sformatf("t2_c_rvalid%0d", i), bus.cpu_rvalid, (i % 2 == 1));
        if (i % 2 == 0) check($sformatf("t2_h_rdata%0d", i), bus.host_rdata, 8'hAB);
        else            check($sformatf("t2_c_rdata%0d", i), bus.cpu_rdata, 8'hCD);
      end
      if (i == 4) begin
        bus.host_req = 1'b0;
        bus.cpu_req  = 1'b0;
      end
      #1;
      if (i < 4) begin
        check($sformatf("t2_hgnt%0d", i), bus.host_gnt, (i % 2 == 0));
        check($sformatf("t2_cgnt%0d", i), bus.cpu_gnt, (i % 2 == 1));
      end
      tick();
    end

    // run low: CPU request ignored; grant as soon as run rises
    run          = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 12'h301;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t3_cgnt_off%0d", i), bus.cpu_gnt, 0);
      tick();
      check($sformatf("t3_en_off%0d", i), bus.mem_en, 0);
    end
    run = 1'b1;
    #1;
    check("t3_cgnt_on", bus.cpu_gnt, 1);
    check("t3_hgnt_on", bus.host_gnt, 0);
    tick();
    check("t3_en",   bus.mem_en, 1);
    check("t3_addr", bus.mem_addr, 12'h301);
    // run falls with the read in flight: it still returns
    bus.cpu_req = 1'b0;
    run         = 1'b0;
    tick();
    check("t3_c_rvalid", bus.cpu_rvalid, 1);
    check("t3_c_rdata",  bus.cpu_rdata, 8'hCD);
    check("t3_h_rvalid", bus.host_rvalid, 0);

    // Reset the cycle after a CPU read grant: its rvalid is dropped
    run          = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 12'h300;
    #1;
    check("t4_cgnt", bus.cpu_gnt, 1);
    tick();
    reset       = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    check("t4_c_rvalid", bus.cpu_rvalid, 0);
    check("t4_en",       bus.mem_en, 0);
    check("t4_we",       bus.mem_we, 0);
    check("t4_addr",     bus.mem_addr, 0);
    check("t4_wdata",    bus.mem_wdata, 0);
    check("t4_c_rdata",  bus.cpu_rdata, 0);
    reset = 1'b1;
    tick();
    check("t4_c_rvalid_a", bus.cpu_rvalid, 0);
    tick();
    check("t4_c_rvalid_b", bus.cpu_rvalid, 0);

    // CPU write into the low region: blocked only with protection built in
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 12'h050;
    bus.cpu_wdata = 8'h55;
    #1;
    check("t5_cgnt", bus.cpu_gnt, 1);
    tick();
    bus.cpu_req = 1'b0;
    check("t5_en",       bus.mem_en, !PROT);
    check("t5_we",       bus.mem_we, !PROT);
    check("t5_prot_err", prot_err, PROT);
    tick();
    tick();
    check("t5_ram",      ram[12'h050], PROT ? 8'h11 : 8'h55);
    check("t5_prot_hold", prot_err, PROT);
    host_write(12'h050, 8'h77);
    check("t5_h_we", bus.mem_we, 1);
    tick();
    tick();
    check("t5_h_ram",   ram[12'h050], 8'h77);
    check("t5_prot_h",  prot_err, PROT);
    // First writable address passes either way
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 12'h200;
    bus.cpu_wdata = 8'h66;
    #1;
    check("t5_lim_gnt", bus.cpu_gnt, 1);
    tick();
    bus.cpu_req = 1'b0;
    check("t5_lim_en",   bus.mem_en, 1);
    check("t5_lim_we",   bus.mem_we, 1);
    check("t5_lim_addr", bus.mem_addr, 12'h200);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
